// File: rtl/pe_array_pkg.sv
// Shared constants and index helpers for the weight-stationary PE array.
// Widths derive from the array parameters so that every file agrees on slicing.
package pe_array_pkg;

    function automatic int result_width(input int data_width, input int weight_width);
        return data_width + weight_width;
    endfunction

    function automatic int kernel_dim(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

    // Row-major position of PE(r,c); also the slice index into weight_array.
    function automatic int pe_idx(input int r, input int c, input int kernel_size);
        return r * kernel_size + c;
    endfunction

endpackage

// File: rtl/pe_array_cell.sv
// One processing element: weight register, data forward register and MAC partial-sum register.
// The MAC always uses the weight held before the current edge, so a reload affects the next edge.
module pe_cell
    import pe_array_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 1,
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = result_width(DATA_WIDTH, WEIGHT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load_weight,
    input  logic [WEIGHT_WIDTH-1:0] new_weight,
    input  logic [DATA_WIDTH-1:0]   data_feed,
    input  logic [RESULT_WIDTH-1:0] psum_feed,
    output logic [DATA_WIDTH-1:0]   data_fwd,
    output logic [RESULT_WIDTH-1:0] psum
);

    logic [WEIGHT_WIDTH-1:0] weight;
    logic [RESULT_WIDTH-1:0] product;
    logic [RESULT_WIDTH-1:0] data_ext;
    logic [RESULT_WIDTH-1:0] weight_ext;

    assign data_ext   = RESULT_WIDTH'(data_feed);
    assign weight_ext = RESULT_WIDTH'(weight);
    // Unsigned product fits exactly in DATA_WIDTH+WEIGHT_WIDTH bits; the sum wraps.
    assign product    = data_ext * weight_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight   <= '0;
            data_fwd <= '0;
            psum     <= '0;
        end else begin
            if (load_weight) begin
                weight <= new_weight;
            end
            data_fwd <= data_feed;
            psum     <= psum_feed + product;
        end
    end

endmodule

// File: rtl/pe_array.sv
// KERNEL_SIZE x KERNEL_SIZE weight-stationary systolic MAC grid; data and partial sums move down
// each column and the bottom row yields one accumulated result per column.
module pe_array
    import pe_array_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 1,
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_SIZE  = 2
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [WEIGHT_WIDTH*kernel_dim(KERNEL_SIZE)-1:0] weight_array,
    input  logic                                        wr_weight_en,
    input  logic [DATA_WIDTH*kernel_dim(KERNEL_SIZE)-1:0]   dataIn,
    input  logic                                        wr_dataIn_en,
    output logic                                        wr_weight_done,
    output logic                                        pe_array_done,
    output logic [result_width(DATA_WIDTH, WEIGHT_WIDTH)*KERNEL_SIZE-1:0] dataOut
);

    localparam int KERNEL_DIM   = kernel_dim(KERNEL_SIZE);
    localparam int RESULT_WIDTH = result_width(DATA_WIDTH, WEIGHT_WIDTH);

    logic [DATA_WIDTH-1:0]   data_feed [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]   data_fwd  [KERNEL_SIZE][KERNEL_SIZE];
    logic [RESULT_WIDTH-1:0] psum_feed [KERNEL_SIZE][KERNEL_SIZE];
    logic [RESULT_WIDTH-1:0] psum      [KERNEL_SIZE][KERNEL_SIZE];
    logic [KERNEL_SIZE-1:0]  valid;

    genvar gi, gj;
    generate
        for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
            for (gj = 0; gj < KERNEL_SIZE; gj++) begin : g_col
                if (gi == 0) begin : g_top
                    // Top row re-feeds its own register when no new word arrives, so it holds.
                    assign data_feed[gi][gj] = wr_dataIn_en ? dataIn[gj*DATA_WIDTH +: DATA_WIDTH]
                                                            : data_fwd[gi][gj];
                    assign psum_feed[gi][gj] = '0;
                end else begin : g_inner
                    assign data_feed[gi][gj] = data_fwd[gi-1][gj];
                    assign psum_feed[gi][gj] = psum[gi-1][gj];
                end

                pe_cell #(
                    .WEIGHT_WIDTH (WEIGHT_WIDTH),
                    .DATA_WIDTH   (DATA_WIDTH),
                    .RESULT_WIDTH (RESULT_WIDTH)
                ) u_cell (
                    .clk         (clk),
                    .rstn        (rstn),
                    .load_weight (wr_weight_en),
                    .new_weight  (weight_array[pe_idx(gi, gj, KERNEL_SIZE)*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
                    .data_feed   (data_feed[gi][gj]),
                    .psum_feed   (psum_feed[gi][gj]),
                    .data_fwd    (data_fwd[gi][gj]),
                    .psum        (psum[gi][gj])
                );
            end
        end

        for (gj = 0; gj < KERNEL_SIZE; gj++) begin : g_out
            assign dataOut[gj*RESULT_WIDTH +: RESULT_WIDTH] = psum[KERNEL_SIZE-1][gj];
        end

        if (KERNEL_DIM > KERNEL_SIZE) begin : g_reserved
            logic unused_data_bits;
            assign unused_data_bits = ^dataIn[DATA_WIDTH*KERNEL_DIM-1:DATA_WIDTH*KERNEL_SIZE];
        end
    endgenerate

    // Valid uses the done flag from before this edge, so a same-edge load does not validate data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_weight_done <= 1'b0;
            valid          <= '0;
        end else begin
            if (wr_weight_en) begin
                wr_weight_done <= 1'b1;
            end
            valid[0] <= wr_dataIn_en & wr_weight_done;
            for (int i = 1; i < KERNEL_SIZE; i++) begin
                valid[i] <= valid[i-1];
            end
        end
    end

    assign pe_array_done = valid[KERNEL_SIZE-1];

endmodule

// File: tb/tb_pe_array.sv
// Directed self-checking bench for pe_array with the default 2x2, 8-bit data, 1-bit weight setup.
module tb_pe_array;

    localparam int WW = 1;
    localparam int DW = 8;
    localparam int KS = 2;
    localparam int KD = KS * KS;
    localparam int RW = DW + WW;

    logic              clk;
    logic              rstn;
    logic [WW*KD-1:0]  weight_array;
    logic              wr_weight_en;
    logic [DW*KD-1:0]  dataIn;
    logic              wr_dataIn_en;
    logic              wr_weight_done;
    logic              pe_array_done;
    logic [RW*KS-1:0]  dataOut;

    int checks;
    int errors;

    pe_array #(
        .WEIGHT_WIDTH (WW),
        .DATA_WIDTH   (DW),
        .KERNEL_SIZE  (KS)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .weight_array   (weight_array),
        .wr_weight_en   (wr_weight_en),
        .dataIn         (dataIn),
        .wr_dataIn_en   (wr_dataIn_en),
        .wr_weight_done (wr_weight_done),
        .pe_array_done  (pe_array_done),
        .dataOut        (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW*KS-1:0] pack_out(input logic [RW-1:0] c0, input logic [RW-1:0] c1);
        return {c1, c0};
    endfunction

    task automatic load_weights(input logic [WW*KD-1:0] w);
        weight_array = w;
        wr_weight_en = 1'b1;
        step();
        wr_weight_en = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        weight_array = '0;
        wr_weight_en = 1'b0;
        dataIn = '0;
        wr_dataIn_en = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (dataOut !== '0 || pe_array_done !== 1'b0 || wr_weight_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: dataOut=%h done=%b wdone=%b, required 0/0/0", dataOut, pe_array_done, wr_weight_done);
        end
        $display("reset: dataOut=%h done=%b wdone=%b", dataOut, pe_array_done, wr_weight_done);
    endtask

    task automatic test_no_weights();
        dataIn = 32'h0000_0709;
        wr_dataIn_en = 1'b1;
        step();
        wr_dataIn_en = 1'b0;
        step();
        checks++;
        if (pe_array_done !== 1'b0 || dataOut !== '0) begin
            errors++;
            $display("FAIL no_weights: done=%b dataOut=%h, required 0 and 0", pe_array_done, dataOut);
        end
        step();
        checks++;
        if (pe_array_done !== 1'b0) begin
            errors++;
            $display("FAIL no_weights_late: done=%b, required 0", pe_array_done);
        end
        $display("no_weights: done=%b dataOut=%h", pe_array_done, dataOut);
    endtask

    task automatic test_simultaneous();
        // Same edge: weight load plus data; data sees old (zero) weights and is not valid.
        weight_array = 4'b1111;
        wr_weight_en = 1'b1;
        dataIn = 32'h0000_0005;
        wr_dataIn_en = 1'b1;
        step();
        wr_weight_en = 1'b0;
        wr_dataIn_en = 1'b0;
        checks++;
        if (wr_weight_done !== 1'b1) begin
            errors++;
            $display("FAIL simul_wdone: wdone=%b, required 1", wr_weight_done);
        end
        step();
        // Row 0 product used weight 0; row 1 adds 5*1 with the new weight.
        checks++;
        if (pe_array_done !== 1'b0 || dataOut !== pack_out(9'd5, 9'd0)) begin
            errors++;
            $display("FAIL simul_data: done=%b dataOut=%h, required 0 and %h", pe_array_done, dataOut, pack_out(9'd5, 9'd0));
        end
        $display("simultaneous: done=%b dataOut=%h", pe_array_done, dataOut);
    endtask

    task automatic test_all_ones();
        load_weights(4'b1111);
        checks++;
        if (wr_weight_done !== 1'b1) begin
            errors++;
            $display("FAIL ones_wdone: wdone=%b, required 1", wr_weight_done);
        end
        dataIn = 32'h0102_0304;
        wr_dataIn_en = 1'b1;
        step();
        wr_dataIn_en = 1'b0;
        checks++;
        if (pe_array_done !== 1'b0) begin
            errors++;
            $display("FAIL ones_early: done=%b, required 0 one cycle in", pe_array_done);
        end
        step();
        checks++;
        if (dataOut !== 18'h00C08 || pe_array_done !== 1'b1) begin
            errors++;
            $display("FAIL ones_result: dataOut=%h done=%b, required 00c08 and 1", dataOut, pe_array_done);
        end
        step();
        checks++;
        if (pe_array_done !== 1'b0) begin
            errors++;
            $display("FAIL ones_done_drop: done=%b, required 0", pe_array_done);
        end
        $display("all_ones: dataOut=%h", dataOut);
    endtask

    task automatic test_mixed_weights();
        load_weights(4'b0101);
        dataIn = 32'hAABB_10FF;
        wr_dataIn_en = 1'b1;
        step();
        wr_dataIn_en = 1'b0;
        step();
        checks++;
        if (dataOut !== pack_out(9'd510, 9'd0) || pe_array_done !== 1'b1) begin
            errors++;
            $display("FAIL mixed: dataOut=%h done=%b, required %h and 1", dataOut, pe_array_done, pack_out(9'd510, 9'd0));
        end
        $display("mixed_weights: dataOut=%h", dataOut);
    endtask

    task automatic test_row0_only();
        load_weights(4'b0011);
        dataIn = 32'h0000_C807;
        wr_dataIn_en = 1'b1;
        step();
        wr_dataIn_en = 1'b0;
        step();
        checks++;
        if (dataOut !== pack_out(9'd7, 9'd200) || pe_array_done !== 1'b1) begin
            errors++;
            $display("FAIL row0_only: dataOut=%h done=%b, required %h and 1", dataOut, pe_array_done, pack_out(9'd7, 9'd200));
        end
        $display("row0_only: dataOut=%h", dataOut);
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] exp_c0 [3];
        exp_c0[0] = 9'd2;
        exp_c0[1] = 9'd4;
        exp_c0[2] = 9'd6;
        load_weights(4'b1111);
        wr_dataIn_en = 1'b1;
        dataIn = 32'h0000_0001;
        step();
        dataIn = 32'h0000_0002;
        step();
        checks++;
        if (dataOut !== pack_out(exp_c0[0], 9'd0) || pe_array_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_0: dataOut=%h done=%b, required %h and 1", dataOut, pe_array_done, pack_out(exp_c0[0], 9'd0));
        end
        dataIn = 32'h0000_0003;
        step();
        checks++;
        if (dataOut !== pack_out(exp_c0[1], 9'd0) || pe_array_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_1: dataOut=%h done=%b, required %h and 1", dataOut, pe_array_done, pack_out(exp_c0[1], 9'd0));
        end
        wr_dataIn_en = 1'b0;
        step();
        checks++;
        if (dataOut !== pack_out(exp_c0[2], 9'd0) || pe_array_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_2: dataOut=%h done=%b, required %h and 1", dataOut, pe_array_done, pack_out(exp_c0[2], 9'd0));
        end
        step();
        checks++;
        if (pe_array_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: done=%b, required 0", pe_array_done);
        end
        $display("back_to_back: dataOut=%h done=%b", dataOut, pe_array_done);
    endtask

    task automatic test_reset_mid_stream();
        dataIn = 32'h0000_0001;
        wr_dataIn_en = 1'b1;
        step();
        step();
        checks++;
        if (pe_array_done !== 1'b1 || dataOut !== pack_out(9'd2, 9'd0)) begin
            errors++;
            $display("FAIL midrst_pre: done=%b dataOut=%h, required 1 and %h", pe_array_done, dataOut, pack_out(9'd2, 9'd0));
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (dataOut !== '0 || pe_array_done !== 1'b0 || wr_weight_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: dataOut=%h done=%b wdone=%b, required 0/0/0", dataOut, pe_array_done, wr_weight_done);
        end
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (wr_weight_done !== 1'b0 || pe_array_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_wdone: wdone=%b done=%b, required 0 and 0", wr_weight_done, pe_array_done);
        end
        step();
        checks++;
        if (pe_array_done !== 1'b0 || dataOut !== '0) begin
            errors++;
            $display("FAIL midrst_after: done=%b dataOut=%h, required 0 and 0", pe_array_done, dataOut);
        end
        wr_dataIn_en = 1'b0;
        $display("reset_mid_stream: dataOut=%h done=%b wdone=%b", dataOut, pe_array_done, wr_weight_done);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_no_weights();
        test_simultaneous();
        test_all_ones();
        test_mixed_weights();
        test_row0_only();
        test_back_to_back();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_array.md
Name: pe_array

Overview:
Weight-stationary 2-D systolic MAC array of KERNEL_SIZE x KERNEL_SIZE processing elements (PEs), row-major.
Each column receives one external data word, which is forwarded down the column. Partial sums flow top to bottom, and the bottom row produces one accumulated result per column.
Used as the compute core of the convolution datapath; a weight-load step is followed by a stream of column data.

Parameters:
WEIGHT_WIDTH  1  bits per weight
DATA_WIDTH  8  bits per data word (unsigned)
KERNEL_SIZE  2  array rows = columns; KERNEL_DIM = KERNEL_SIZE*KERNEL_SIZE; RESULT_WIDTH = DATA_WIDTH+WEIGHT_WIDTH (derived localparams)

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
weight_array  in  WEIGHT_WIDTH*KERNEL_DIM  weight of PE idx=r*KERNEL_SIZE+c at bits [idx*WEIGHT_WIDTH +: WEIGHT_WIDTH]
wr_weight_en  in  1  load weight_array into all PE weight registers
dataIn  in  DATA_WIDTH*KERNEL_DIM  column c input at bits [c*DATA_WIDTH +: DATA_WIDTH], c<KERNEL_SIZE; upper slices reserved/ignored
wr_dataIn_en  in  1  inject dataIn into row 0 this cycle
wr_weight_done  out  1  weights loaded (sticky)
pe_array_done  out  1  dataOut holds a valid result
dataOut  out  RESULT_WIDTH*KERNEL_SIZE  bottom-row result of column c at bits [c*RESULT_WIDTH +: RESULT_WIDTH]

Behaviour:
- Reset (rstn=0, async): all weight, data, psum and valid registers and all outputs go to 0.
- Weight load: on a clk edge with wr_weight_en=1, every PE captures its weight slice. wr_weight_done rises on that same edge and stays 1 until reset. Reloading while data flows takes effect from the next edge; in-flight sums mix old and new weights (no protection).
- PE(r,c), registered at every edge:
  - data_o <= data_i (row 0 takes the dataIn column slice only when wr_dataIn_en=1; otherwise it holds)
  - psum_o <= psum_i + data_i*weight
  - psum_i = 0 for row 0; otherwise psum_o of PE(r-1,c)
  - data_i of row r>0 = data_o of PE(r-1,c)
- Arithmetic: unsigned. The product is zero-extended to RESULT_WIDTH; the sum wraps modulo 2^RESULT_WIDTH (no saturation).
- dataOut = psum_o of the bottom row.
- Latency is exactly KERNEL_SIZE cycles from the sampling edge to dataOut. Throughput is one vector per cycle, back-to-back.
- Valid pipeline: a KERNEL_SIZE-deep shift register fed by (wr_dataIn_en & wr_weight_done). pe_array_done = last stage, aligned with dataOut.
- With wr_dataIn_en held high and dataIn constant, dataOut and pe_array_done remain steady.
- Data injected before wr_weight_done is computed with reset (0) weights and is not flagged valid.
- Reset mid-stream: all in-flight results are discarded, pe_array_done=0 immediately, and weights must be reloaded.
- Simultaneous wr_weight_en and wr_dataIn_en: the data sampled on that edge uses the old weights and is not flagged valid if no weights were previously loaded.

Decomposition:
- Shared package: RESULT_WIDTH/KERNEL_DIM derivation constants and the slice-index helper idx = r*KERNEL_SIZE+c.
- One sub-module, pe_cell: weight register, data forward register, MAC psum register.
- pe_array holds generate loops for the grid, the valid shift register and the done logic.

Test Plan:
- Reset, then weights 4'b1111 with wr_weight_en=1; on the following edge wr_weight_done=1. Then dataIn=32'h01020304, wr_dataIn_en=1 → columns (c0=4, c1=3); after 2 cycles dataOut=18'h00C08 (c1=6, c0=8), pe_array_done=1.
- Weights 4'b0101 (PE0, PE2 =1), dataIn low bytes c0=8'hFF, c1=8'h10 → dataOut c0=9'd510, c1=0.
- Weights 4'b0011 (row 0 only), c0=7, c1=200 → c0=7, c1=200 after 2 cycles.
- Streaming: c0 = 1,2,3 on consecutive cycles, weights all 1 → dataOut c0 = 2,4,6 on consecutive cycles, pe_array_done high continuously.
- wr_dataIn_en pulsed without prior weight load → pe_array_done stays 0, dataOut=0.
- Assert rstn=0 one cycle into a stream → outputs 0 at once; after release wr_weight_done=0 until the next load.
